// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode: absorbs decode back-pressure,
// stalls fetch when full, flushes wrong-path words on a branch-fail redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_ins,
  output logic          if_stall,
  input  logic          fail,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_ins,
  output logic [AW:0]   count,
  output logic [15:0]   flush_cnt
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [31:0] pc_mem  [DEPTH];
  logic [31:0] ins_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [15:0]   flush_cnt_q;

  logic enq;
  logic deq;
  logic flush_hit;

  // Handshakes: fetch -> queue transfers whenever if_stall is low (fetch has
  // no valid of its own; it presents a word every non-stalled cycle).
  // Queue -> decode transfers on id_valid & id_ready. fail cancels both.
  assign if_stall  = (count_q == FULL_CNT);
  assign id_valid  = (count_q != '0);
  assign enq       = ~if_stall & ~fail;
  assign deq       = id_valid & id_ready & ~fail;
  assign flush_hit = fail & id_valid;

  assign id_pc     = id_valid ? pc_mem[rd_ptr]  : 32'h0;
  assign id_ins    = id_valid ? ins_mem[rd_ptr] : 32'h0;
  assign count     = count_q;
  assign flush_cnt = flush_cnt_q;

  // Storage carries no reset; the occupancy count decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]  <= if_pc;
      ins_mem[wr_ptr] <= if_ins;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (fail) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Only flushes that actually discarded buffered words are counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
    end else if (flush_hit && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived vector table, async reset sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic [31:0]   if_pc;
  logic [31:0]   if_ins;
  logic          if_stall;
  logic          fail;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_ins;
  logic [AW:0]   count;
  logic [15:0]   flush_cnt;

  int checks;
  int errors;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_pc     (if_pc),
    .if_ins    (if_ins),
    .if_stall  (if_stall),
    .fail      (fail),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_ins    (id_ins),
    .count     (count),
    .flush_cnt (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fetch model and reference model state
  logic [31:0] fpc;
  logic [63:0] exp_q[$];
  int          m_flush;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h1300_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic fl, input logic [31:0] new_pc);
    id_ready = rdy;
    fail     = fl;
    if_pc    = fpc;
    if_ins   = ins_of(fpc);
    @(posedge clk);
    #1;
    // reference model: apply the edge's rules to the pre-edge state
    if (fl) begin
      if (exp_q.size() != 0 && m_flush != 16'hFFFF) m_flush++;
      exp_q.delete();
      fpc = new_pc;
    end else begin
      bit stall_b;
      stall_b = (exp_q.size() == DEPTH);
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (!stall_b) begin
        exp_q.push_back({fpc, ins_of(fpc)});
        fpc = fpc + 32'd4;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    e_pc  = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
    e_ins = (exp_q.size() != 0) ? exp_q[0][31:0]  : 32'h0;
    chk({tag, ".count"},     32'(count),     32'(exp_q.size()));
    chk({tag, ".id_valid"},  32'(id_valid),  32'(exp_q.size() != 0));
    chk({tag, ".id_pc"},     id_pc,          e_pc);
    chk({tag, ".id_ins"},    id_ins,         e_ins);
    chk({tag, ".if_stall"},  32'(if_stall),  32'(exp_q.size() == DEPTH));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
  endtask

  typedef struct {
    logic        rdy;
    logic        fl;
    logic [31:0] new_pc;
    int          e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_stall;
    int          e_flush;
  } vec_t;

  vec_t tbl[18];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; fail = 1'b0; id_ready = 1'b0;
    fpc = 32'h0; if_pc = 32'h0; if_ins = ins_of(32'h0);
    m_flush = 0;

    // stream, fill to full with held word, full+fail+ready, flush of 3, empty flush
    tbl[0]  = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h0,   1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h4,   1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h8,   1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h8,   1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   3, 1'b1, 32'h8,   1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   4, 1'b1, 32'h8,   1'b1, 0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   4, 1'b1, 32'h8,   1'b1, 0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   3, 1'b1, 32'hC,   1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   3, 1'b1, 32'h10,  1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   4, 1'b1, 32'h10,  1'b1, 0};
    tbl[10] = '{1'b1, 1'b1, 32'h40,  0, 1'b0, 32'h0,   1'b0, 1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h40,  1'b0, 1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h40,  1'b0, 1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   3, 1'b1, 32'h40,  1'b0, 1};
    tbl[14] = '{1'b0, 1'b1, 32'h80,  0, 1'b0, 32'h0,   1'b0, 2};
    tbl[15] = '{1'b1, 1'b1, 32'h100, 0, 1'b0, 32'h0,   1'b0, 2};
    tbl[16] = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h100, 1'b0, 2};
    tbl[17] = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h104, 1'b0, 2};

    // reset held across several edges
    repeat (3) @(posedge clk);
    #1;
    chk("rst.id_valid", 32'(id_valid), 32'h0);
    chk("rst.id_ins",   id_ins,        32'h0);
    chk("rst.id_pc",    id_pc,         32'h0);
    chk("rst.if_stall", 32'(if_stall), 32'h0);
    chk("rst.count",    32'(count),    32'h0);
    chk("rst.flush",    32'(flush_cnt), 32'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      string t;
      logic [31:0] e_ins;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].rdy, tbl[i].fl, tbl[i].new_pc);
      e_ins = tbl[i].e_valid ? ins_of(tbl[i].e_pc) : 32'h0;
      chk({t, ".count"},     32'(count),     32'(tbl[i].e_count));
      chk({t, ".id_valid"},  32'(id_valid),  32'(tbl[i].e_valid));
      chk({t, ".id_pc"},     id_pc,          tbl[i].e_pc);
      chk({t, ".id_ins"},    id_ins,         e_ins);
      chk({t, ".if_stall"},  32'(if_stall),  32'(tbl[i].e_stall));
      chk({t, ".flush_cnt"}, 32'(flush_cnt), 32'(tbl[i].e_flush));
    end

    // random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic rdy, fl;
      rdy = ($urandom_range(0, 3) != 0);
      if (n % 50 < 10) rdy = 1'b0;
      fl  = ($urandom_range(0, 15) == 0);
      drive(rdy, fl, {$urandom_range(0, 32'hFFFF), 2'b00} & 32'h0003_FFFC);
      check_model($sformatf("rnd%0d", n));
    end

    // async reset mid-cycle clears state without a clock edge
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("arst.count",    32'(count),     32'h0);
    chk("arst.id_valid", 32'(id_valid),  32'h0);
    chk("arst.id_pc",    id_pc,          32'h0);
    chk("arst.if_stall", 32'(if_stall),  32'h0);
    chk("arst.flush",    32'(flush_cnt), 32'h0);
    exp_q.delete();
    m_flush = 0;
    fpc = 32'h200;
    #1 rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      drive(($urandom_range(0, 1) != 0), ($urandom_range(0, 19) == 0), 32'h300);
      check_model($sformatf("post%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
